// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latches NSRC sources and drives a single ExtIRQ/ExtIAck/ERet handshake.
// The winner is the lowest-index pending source by default; define IRQ_RR_EN for round-robin.
module irq_arbiter #(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            cfg_we,
    input  logic [NSRC-1:0] cfg_mask,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    input  logic            ExtIAck,
    input  logic            ERet,
    output logic [NSRC-1:0] pending,
    output logic            in_service,
    output logic            irq_ovf
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          stateReg, stateNext;
    logic [NSRC-1:0] prevSrc;
    logic [NSRC-1:0] maskReg, maskNext;
    logic [NSRC-1:0] pendReg, pendNext;
    logic [NSRC-1:0] srcEdge, ackOneHot, eligible;
    logic [IDW-1:0]  curIdReg, curIdNext, winner;
    logic            extIrqReg, extIrqNext;
    logic            inSvcReg, inSvcNext;
    logic            ovfReg, ovfNext;
    logic            ackTake;

    assign srcEdge  = src_irq & ~prevSrc;
    assign eligible = pendReg & maskReg;
    assign ackTake  = (stateReg == REQ) && ExtIAck;

    // One-hot of the source whose pending bit is consumed by this cycle's acknowledge.
    for (genvar gi = 0; gi < NSRC; gi++) begin : gAckSel
        assign ackOneHot[gi] = ackTake && (curIdReg == IDW'(gi));
    end

`ifdef IRQ_RR_EN
    logic [IDW-1:0] rrPtrReg, rrPtrNext;

    // Scan from rrPtr upward with wrap; the first eligible index wins.
    always_comb begin
        int idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int off = 0; off < NSRC; off++) begin
            idx = int'(rrPtrReg) + off;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (!found && eligible[IDW'(idx)]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        rrPtrNext = rrPtrReg;
        if (ackTake) begin
            rrPtrNext = (curIdReg == IDW'(NSRC - 1)) ? '0 : curIdReg + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtrReg <= '0;
        end else begin
            rrPtrReg <= rrPtrNext;
        end
    end
`else
    // Descending scan so the lowest eligible index is the last (winning) assignment.
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[IDW'(i)]) begin
                winner = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        stateNext  = stateReg;
        curIdNext  = curIdReg;
        extIrqNext = extIrqReg;
        inSvcNext  = inSvcReg;
        maskNext   = cfg_we ? cfg_mask : maskReg;
        // A fresh edge on the acknowledged source re-arms it and is not an overflow.
        pendNext   = (pendReg & ~ackOneHot) | srcEdge;
        ovfNext    = (ovfReg & ~cfg_we) | (|(srcEdge & pendReg & ~ackOneHot));
        case (stateReg)
            IDLE: begin
                if (|eligible) begin
                    curIdNext  = winner;
                    extIrqNext = 1'b1;
                    stateNext  = REQ;
                end
            end
            REQ: begin
                if (ExtIAck) begin
                    extIrqNext = 1'b0;
                    inSvcNext  = 1'b1;
                    stateNext  = SERVICE;
                end
            end
            SERVICE: begin
                if (ERet) begin
                    inSvcNext = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= IDLE;
            prevSrc   <= '0;
            maskReg   <= '1;
            pendReg   <= '0;
            curIdReg  <= '0;
            extIrqReg <= 1'b0;
            inSvcReg  <= 1'b0;
            ovfReg    <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            prevSrc   <= src_irq;
            maskReg   <= maskNext;
            pendReg   <= pendNext;
            curIdReg  <= curIdNext;
            extIrqReg <= extIrqNext;
            inSvcReg  <= inSvcNext;
            ovfReg    <= ovfNext;
        end
    end

    assign ExtIRQ     = extIrqReg;
    assign irq_id     = curIdReg;
    assign pending    = pendReg;
    assign in_service = inSvcReg;
    assign irq_ovf    = ovfReg;

endmodule
